// File: rtl/pc_redirect_sequencer.sv
// Fetch-stage PC register: rebuilds J/branch/JR targets from decode redirects
// and sequences the fetch PC through BOOT, RUN and the post-redirect BUBBLE.
module pc_redirect_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_W     = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Stall,
  input  logic [PC_W-1:0] DecPCPlus4,
  input  logic            JumpRegEn,
  input  logic [PC_W-1:0] JumpRegAddr,
  input  logic            JumpEn,
  input  logic [25:0]     JumpIndex,
  input  logic            BranchEn,
  input  logic [15:0]     BranchOffset,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PCPlus4,
  output logic            FetchValid,
  output logic            Flush,
  output logic            Misaligned
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            misaligned_q, misaligned_d;
  logic            runValid_q;

  logic            redirect;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] branchDisp;

  assign branchDisp = {{14{BranchOffset[15]}}, BranchOffset, 2'b00};
  assign redirect   = JumpRegEn | JumpEn | BranchEn;

  // Priority JR > J > branch; the low two bits of a JR target are dropped.
  always_comb begin
    target = DecPCPlus4 + branchDisp;
    if (JumpRegEn) begin
      target = {JumpRegAddr[PC_W-1:2], 2'b00};
    end else if (JumpEn) begin
      target = {DecPCPlus4[PC_W-1:28], JumpIndex, 2'b00};
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_d      = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (!Stall) begin
          if (redirect) begin
            pc_d         = target;
            flush_d      = 1'b1;
            misaligned_d = JumpRegEn & (JumpRegAddr[1:0] != 2'b00);
            state_d      = BUBBLE;
          end else begin
            pc_d = PCPlus4;
          end
        end
      end
      BUBBLE: begin
        state_d = RUN;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      flush_q      <= 1'b0;
      misaligned_q <= 1'b0;
      runValid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_q      <= flush_d;
      misaligned_q <= misaligned_d;
      runValid_q   <= (state_d == RUN);
    end
  end

  // A stalled RUN cycle fetches nothing, so validity is gated by the live Stall.
  assign PC         = pc_q;
  assign PCPlus4    = pc_q + 32'd4;
  assign FetchValid = runValid_q & ~Stall;
  assign Flush      = flush_q;
  assign Misaligned = misaligned_q;

endmodule
